// File: rtl/nco_pkg.sv
// Shared constants and FSM encodings for the NCO sweep controller.
// Defaults match the counter block's table size and step width.
package nco_pkg;

    localparam int DEPTH_DEF   = 256;
    localparam int AW_DEF      = $clog2(DEPTH_DEF);
    localparam int DATA_W_DEF  = 32;
    localparam int DELTA_W_DEF = 4;
    localparam int DWELL_W_DEF = 16;
    localparam int PHASE_W_DEF = 8;

    localparam logic [3:0] WMASK_ALL = 4'hF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_PRELOAD = 3'd2;
    localparam logic [2:0] S_SWEEP   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

endpackage

// File: rtl/nco_table_loader.sv
// Streams DEPTH words from a request/valid source into the SRAM write port.
// load_done pulses in the same cycle as the final write.
module nco_table_loader
    import nco_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              go,
    output logic              src_req,
    output logic [AW-1:0]     src_addr,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              csb0,
    output logic              web0,
    output logic [3:0]        wmask0,
    output logic [AW-1:0]     addr0,
    output logic [DATA_W-1:0] din0,
    output logic              load_done
);

    logic              r_req;
    logic [AW-1:0]     r_addr;
    logic              r_csb;
    logic              r_web;
    logic [3:0]        r_wmask;
    logic [AW-1:0]     r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              w_last;

    assign w_last = (r_addr == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_done  <= 1'b0;
            if (go) begin
                r_req  <= 1'b1;
                r_addr <= '0;
            end else if (r_req && src_valid) begin
                r_csb   <= 1'b0;
                r_web   <= 1'b0;
                r_wmask <= WMASK_ALL;
                r_waddr <= r_addr;
                r_wdata <= src_data;
                if (w_last) begin
                    r_req  <= 1'b0;
                    r_addr <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + AW'(1);
                end
            end
        end
    end

    assign src_req   = r_req;
    assign src_addr  = r_addr;
    assign csb0      = r_csb;
    assign web0      = r_web;
    assign wmask0    = r_wmask;
    assign addr0     = r_waddr;
    assign din0      = r_wdata;
    assign load_done = r_done;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sequencer: table load, phase preload, then a dwell-timed delta sweep
// for the counter phase accumulator.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               cfg_skip_load,
    input  logic [DELTA_W-1:0] cfg_delta_start,
    input  logic [DELTA_W-1:0] cfg_delta_stop,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic               cfg_up_dn,
    output logic               src_req,
    output logic [AW-1:0]      src_addr,
    input  logic               src_valid,
    input  logic [DATA_W-1:0]  src_data,
    output logic               csb0,
    output logic               web0,
    output logic [3:0]         wmask0,
    output logic [AW-1:0]      addr0,
    output logic [DATA_W-1:0]  din0,
    output logic               preload,
    output logic [PHASE_W-1:0] pl_data,
    output logic               up_dn,
    output logic [DELTA_W-1:0] delta,
    output logic               busy,
    output logic               done
);

    logic [2:0]         r_state;
    logic [DELTA_W-1:0] r_dstart;
    logic [DELTA_W-1:0] r_dstop;
    logic [DWELL_W-1:0] r_dwell;
    logic [PHASE_W-1:0] r_phase;
    logic               r_up;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_preload;
    logic [PHASE_W-1:0] r_pl_data;
    logic               r_up_dn;
    logic [DELTA_W-1:0] r_delta;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_go;
    logic               w_load_done;
    logic [DWELL_W:0]   w_cnt_nx;
    logic               w_last;
    logic [DELTA_W-1:0] w_delta_nx;

    assign w_accept = start && !abort &&
                      (r_state == S_IDLE || r_state == S_DONE);
    assign w_go     = w_accept && !cfg_skip_load;

    // dwell of zero falls out as one cycle: cnt+1 >= 0 is always true
    assign w_cnt_nx   = {1'b0, r_cnt} + {{DWELL_W{1'b0}}, 1'b1};
    assign w_last     = (w_cnt_nx >= {1'b0, r_dwell});
    assign w_delta_nx = (r_dstart < r_dstop) ? r_delta + DELTA_W'(1)
                                             : r_delta - DELTA_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dstart  <= '0;
            r_dstop   <= '0;
            r_dwell   <= '0;
            r_phase   <= '0;
            r_up      <= 1'b1;
            r_cnt     <= '0;
            r_preload <= 1'b0;
            r_pl_data <= '0;
            r_up_dn   <= 1'b1;
            r_delta   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_preload <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_delta <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_dstart <= cfg_delta_start;
                            r_dstop  <= cfg_delta_stop;
                            r_dwell  <= cfg_dwell;
                            r_phase  <= cfg_phase;
                            r_up     <= cfg_up_dn;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            if (cfg_skip_load) begin
                                r_state   <= S_PRELOAD;
                                r_preload <= 1'b1;
                                r_pl_data <= cfg_phase;
                                r_up_dn   <= cfg_up_dn;
                                r_delta   <= cfg_delta_start;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_load_done) begin
                            r_state   <= S_PRELOAD;
                            r_preload <= 1'b1;
                            r_pl_data <= r_phase;
                            r_up_dn   <= r_up;
                            r_delta   <= r_dstart;
                        end
                    end
                    S_PRELOAD: begin
                        r_state <= S_SWEEP;
                        r_cnt   <= '0;
                    end
                    S_SWEEP: begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_delta == r_dstop) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_delta <= w_delta_nx;
                            end
                        end else begin
                            r_cnt <= w_cnt_nx[DWELL_W-1:0];
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    nco_table_loader #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .clr       (abort),
        .go        (w_go),
        .src_req   (src_req),
        .src_addr  (src_addr),
        .src_valid (src_valid),
        .src_data  (src_data),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .load_done (w_load_done)
    );

    assign preload = r_preload;
    assign pl_data = r_pl_data;
    assign up_dn   = r_up_dn;
    assign delta   = r_delta;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: load, backpressure, sweeps,
// abort/restart and reset recovery with hand-computed expectations.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        cfg_skip_load;
    logic [3:0]  cfg_delta_start;
    logic [3:0]  cfg_delta_stop;
    logic [15:0] cfg_dwell;
    logic [7:0]  cfg_phase;
    logic        cfg_up_dn;
    logic        src_req;
    logic [7:0]  src_addr;
    logic        src_valid;
    logic [31:0] src_data;
    logic [31:0] data_base;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        preload;
    logic [7:0]  pl_data;
    logic        up_dn;
    logic [3:0]  delta;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign src_data = data_base + {24'd0, src_addr};

    nco_sweep_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_skip_load   (cfg_skip_load),
        .cfg_delta_start (cfg_delta_start),
        .cfg_delta_stop  (cfg_delta_stop),
        .cfg_dwell       (cfg_dwell),
        .cfg_phase       (cfg_phase),
        .cfg_up_dn       (cfg_up_dn),
        .src_req         (src_req),
        .src_addr        (src_addr),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .csb0            (csb0),
        .web0            (web0),
        .wmask0          (wmask0),
        .addr0           (addr0),
        .din0            (din0),
        .preload         (preload),
        .pl_data         (pl_data),
        .up_dn           (up_dn),
        .delta           (delta),
        .busy            (busy),
        .done            (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic skip, input logic [3:0] ds,
                           input logic [3:0] de, input logic [15:0] dw,
                           input logic [7:0] ph, input logic ud);
        cfg_skip_load   = skip;
        cfg_delta_start = ds;
        cfg_delta_stop  = de;
        cfg_dwell       = dw;
        cfg_phase       = ph;
        cfg_up_dn       = ud;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sram"}, {csb0, web0, wmask0, addr0, din0},
            {1'b1, 1'b1, 4'h0, 8'h00, 32'h0});
        chk({tag, "_ctr"}, {preload, pl_data, up_dn, delta},
            {1'b0, 8'h00, 1'b1, 4'h0});
        chk({tag, "_stat"}, {src_req, src_addr, busy, done},
            {1'b0, 8'h00, 1'b0, 1'b0});
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] ea;
        logic        v;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        src_valid = 1'b0;
        data_base = 32'hA500_0000;
        set_cfg(1'b0, 4'd2, 4'd2, 16'd1, 8'h11, 1'b1);
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_vals("reset");

        // 1: full table load with source always valid
        src_valid = 1'b1;
        pulse_start();
        chk("t1_start", {busy, done, src_req, src_addr, csb0},
            {1'b1, 1'b0, 1'b1, 8'h00, 1'b1});
        for (int i = 0; i < 256; i++) begin
            tick();
            a = i[7:0];
            chk("t1_write", {preload, csb0, web0, wmask0, addr0, din0},
                {1'b0, 1'b0, 1'b0, 4'hF, a, 32'hA500_0000 + i});
        end
        chk("t1_req_drop", {src_req, src_addr}, {1'b0, 8'h00});
        tick();
        chk("t1_preload", {preload, pl_data, up_dn, delta, csb0, web0},
            {1'b1, 8'h11, 1'b1, 4'd2, 1'b1, 1'b1});
        tick();
        chk("t1_sweep", {preload, delta, done, busy},
            {1'b0, 4'd2, 1'b0, 1'b1});
        tick();
        chk("t1_done", {delta, done, busy}, {4'd2, 1'b1, 1'b0});

        // 2: source backpressure, valid every third cycle
        src_valid = 1'b0;
        data_base = 32'h5A00_0000;
        set_cfg(1'b0, 4'd6, 4'd6, 16'd0, 8'h22, 1'b0);
        pulse_start();
        ea = 0;
        for (int k = 0; k < 3 * 256; k++) begin
            v = (k % 3 == 2);
            src_valid = v;
            tick();
            if (v) begin
                chk("t2_write", {csb0, web0, addr0, din0},
                    {1'b0, 1'b0, ea[7:0], 32'h5A00_0000 + ea});
                ea++;
            end else begin
                chk("t2_hold", {csb0, web0, src_req, src_addr},
                    {1'b1, 1'b1, 1'b1, ea[7:0]});
            end
        end
        chk("t2_count", {src_req, src_addr, ea}, {1'b0, 8'h00, 32'd256});
        src_valid = 1'b1;
        tick();
        chk("t2_preload", {preload, pl_data, up_dn, delta, csb0},
            {1'b1, 8'h22, 1'b0, 4'd6, 1'b1});
        tick();
        chk("t2_ignored", {csb0, web0, src_req, delta},
            {1'b1, 1'b1, 1'b0, 4'd6});
        tick();
        chk("t2_done", {done, busy, csb0}, {1'b1, 1'b0, 1'b1});
        src_valid = 1'b0;

        // 3: up sweep 1..5, dwell 1000, start pulse and cfg change ignored
        set_cfg(1'b1, 4'd1, 4'd5, 16'd1000, 8'h40, 1'b0);
        pulse_start();
        chk("t3_preload", {preload, pl_data, up_dn, delta, busy, done},
            {1'b1, 8'h40, 1'b0, 4'd1, 1'b1, 1'b0});
        for (int c = 1; c <= 5000; c++) begin
            tick();
            a = 8'd1 + 8'((c - 1) / 1000);
            chk("t3_delta", {preload, done, delta}, {1'b0, 1'b0, a[3:0]});
            if (c == 2500) begin
                set_cfg(1'b1, 4'd9, 4'd2, 16'd3, 8'h00, 1'b1);
                start = 1'b1;
            end
            if (c == 2501) start = 1'b0;
        end
        tick();
        chk("t3_done", {done, busy, delta, up_dn},
            {1'b1, 1'b0, 4'd5, 1'b0});
        tick();
        chk("t3_hold", {done, delta}, {1'b1, 4'd5});

        // 4: down sweep with dwell 0, then degenerate start==stop
        set_cfg(1'b1, 4'd9, 4'd7, 16'd0, 8'h05, 1'b1);
        pulse_start();
        chk("t4_preload", {preload, delta, done}, {1'b1, 4'd9, 1'b0});
        tick();
        chk("t4_d9", {delta, done}, {4'd9, 1'b0});
        tick();
        chk("t4_d8", {delta, done}, {4'd8, 1'b0});
        tick();
        chk("t4_d7", {delta, done}, {4'd7, 1'b0});
        tick();
        chk("t4_done", {delta, done, busy}, {4'd7, 1'b1, 1'b0});
        set_cfg(1'b1, 4'd3, 4'd3, 16'd4, 8'h06, 1'b1);
        pulse_start();
        chk("t4_eq_preload", {preload, delta, busy, done},
            {1'b1, 4'd3, 1'b1, 1'b0});
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_eq_hold", {delta, done}, {4'd3, 1'b0});
        end
        tick();
        chk("t4_eq_done", {delta, done, busy}, {4'd3, 1'b1, 1'b0});

        // 5: abort at load index 100, reload, start during sweep
        data_base = 32'hA500_0000;
        src_valid = 1'b1;
        set_cfg(1'b0, 4'd2, 4'd4, 16'd3, 8'h33, 1'b1);
        pulse_start();
        repeat (100) tick();
        chk("t5_idx100", {src_req, src_addr, addr0},
            {1'b1, 8'd100, 8'd99});
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_abort", {csb0, web0, src_req, preload, busy, done, delta},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        tick();
        chk("t5_idle", {csb0, src_req, busy}, {1'b1, 1'b0, 1'b0});
        pulse_start();
        chk("t5_restart", {src_req, src_addr, busy}, {1'b1, 8'h00, 1'b1});
        tick();
        chk("t5_reload0", {csb0, web0, addr0, din0},
            {1'b0, 1'b0, 8'h00, 32'hA500_0000});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        src_valid = 1'b0;
        chk("t5_abort2", {csb0, busy}, {1'b1, 1'b0});
        set_cfg(1'b1, 4'd2, 4'd4, 16'd3, 8'h44, 1'b0);
        pulse_start();
        chk("t5_preload", {preload, pl_data, delta}, {1'b1, 8'h44, 4'd2});
        for (int c = 1; c <= 9; c++) begin
            tick();
            a = 8'd2 + 8'((c - 1) / 3);
            chk("t5_delta", {done, delta}, {1'b0, a[3:0]});
            if (c == 4) begin
                set_cfg(1'b1, 4'd15, 4'd15, 16'd1, 8'h00, 1'b1);
                start = 1'b1;
            end
            if (c == 5) start = 1'b0;
        end
        tick();
        chk("t5_done", {done, delta, preload}, {1'b1, 4'd4, 1'b0});

        // 6: cfg changes mid-sweep, then reset at delta 3
        set_cfg(1'b1, 4'd1, 4'd6, 16'd2, 8'h77, 1'b0);
        pulse_start();
        chk("t6_preload", {preload, pl_data, delta}, {1'b1, 8'h77, 4'd1});
        for (int c = 1; c <= 5; c++) begin
            tick();
            a = 8'd1 + 8'((c - 1) / 2);
            chk("t6_delta", {done, delta}, {1'b0, a[3:0]});
            if (c == 1) set_cfg(1'b0, 4'd0, 4'd2, 16'd1, 8'h00, 1'b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("t6_reset");

        // reset in the middle of a load leaves no write behind
        src_valid = 1'b1;
        pulse_start();
        tick();
        tick();
        chk("t6_load_mid", {csb0, addr0}, {1'b0, 8'd1});
        reset = 1'b1;
        tick();
        chk_reset_vals("t6_reset_load");
        reset = 1'b0;
        tick();
        chk("t6_no_write", {csb0, web0, src_req, busy},
            {1'b1, 1'b1, 1'b0, 1'b0});
        src_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer for the `counter` phase-accumulator/waveform block. On `start` it:
- copies a waveform table from an external word source into the counter's SRAM write port;
- issues a phase preload;
- steps the counter's `delta` through a programmed range, holding each value for a programmed dwell.

It replaces bench-driven table init and delta stepping, so the counter runs autonomously in-system.

Parameters:
DEPTH, 256, table entries written (power of two); address width AW = clog2(DEPTH)
DATA_W, 32, table word width
DELTA_W, 4, width of delta and sweep config
DWELL_W, 16, width of dwell counter
PHASE_W, 8, width of preload phase

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begin a sequence (accepted in IDLE or DONE only)
abort  in  1  pulse; return to IDLE from any state
cfg_skip_load  in  1  skip the table load phase
cfg_delta_start  in  DELTA_W  first delta
cfg_delta_stop  in  DELTA_W  last delta
cfg_dwell  in  DWELL_W  cycles per delta step (0 treated as 1)
cfg_phase  in  PHASE_W  preload value
cfg_up_dn  in  1  counter direction
src_req  out  1  table word request
src_addr  out  AW  requested table index
src_valid  in  1  src_data valid for current src_addr
src_data  in  DATA_W  table word
csb0  out  1  SRAM chip select, active low
web0  out  1  SRAM write enable, active low
wmask0  out  4  byte write mask
addr0  out  AW  SRAM address
din0  out  DATA_W  SRAM write data
preload  out  1  counter preload strobe
pl_data  out  PHASE_W  counter preload value
up_dn  out  1  counter direction
delta  out  DELTA_W  counter step
busy  out  1  sequence in progress
done  out  1  sweep completed; held until next start/abort/reset

Behaviour:
- All outputs are registered. Values on reset:
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0
  - preload=0, pl_data=0, up_dn=1, delta=0
  - src_req=0, src_addr=0, busy=0, done=0
- FSM states: IDLE, LOAD, PRELOAD, SWEEP, DONE.
- Config latching: every cfg_* input is latched on the cycle `start` is accepted. Later changes to cfg_* have no effect on the running sequence.
- IDLE/DONE + start:
  - Next state is LOAD, or PRELOAD if cfg_skip_load=1.
  - busy=1 and done=0 from the next cycle.
- LOAD:
  - src_req=1 while waiting. src_addr starts at 0 and must stay stable until src_valid.
  - On src_valid && src_req, the next cycle has csb0=0, web0=0, wmask0=4'hF, addr0=src_addr, din0=src_data for exactly one cycle.
  - On the same accept, src_addr increments and src_req stays high.
  - Outside write cycles: csb0=1, web0=1.
  - src_valid while src_req=0 is ignored.
  - After accepting index DEPTH-1: src_req drops, src_addr returns to 0, and the final write still completes. The next state is PRELOAD.
  - A full load with src_valid tied high takes DEPTH+1 cycles.
- PRELOAD:
  - One cycle with preload=1, pl_data=latched phase, up_dn=latched up_dn, delta=delta_start.
  - Next state is SWEEP.
- SWEEP:
  - delta holds each value for max(dwell,1) cycles, counted from the first SWEEP cycle.
  - Step direction: +1 if start<stop, -1 if start>stop. If start==stop there is a single step.
  - After the dwell at delta_stop completes, the next state is DONE.
  - Arithmetic never wraps: delta never passes stop.
- DONE:
  - busy=0, done=1.
  - delta holds at stop, so the counter keeps running at the final rate.
- abort (any state):
  - Next cycle: IDLE, csb0=1, web0=1, src_req=0, preload=0, busy=0, done=0, delta=0.
  - abort has priority over start on the same cycle.
- start while busy is ignored.
- reset mid-LOAD or mid-SWEEP forces all reset values on the next edge. No partial write is issued after reset.

Decomposition:
- Package `nco_pkg`:
  - FSM state enum;
  - DEPTH/AW/DATA_W/DELTA_W defaults;
  - SRAM write-mask constant WMASK_ALL=4'hF.
- One natural sub-module, `nco_table_loader`: the LOAD-phase request/accept/write pipeline.
  - Inputs: go, source handshake.
  - Outputs: SRAM port, load_done.
- The top-level FSM holds preload, sweep and dwell logic.

Test Plan:
1. Table load: reset 3 cycles; start with src_valid=1, src_data=0xA5000000+addr. Expect 256 SRAM writes at addr0 0..255 with matching din0, and preload pulse at cycle 258 after start.
2. Source backpressure: src_valid asserted every 3rd cycle. Expect src_addr stable between accepts and exactly one write per accept. No writes while src_valid=0.
3. Up sweep: skip_load=1, delta 1→5, dwell=1000, phase=0x40. Expect preload=1 with pl_data=0x40 for one cycle, then delta=1,2,3,4,5 each 1000 cycles, then done=1 at cycle 5001 of SWEEP.
4. Down and degenerate sweeps: start=9, stop=7, dwell=0. Expect delta 9,8,7 one cycle each, then done. A separate run with start=stop=3, dwell=4 gives delta=3 for 4 cycles, then done.
5. Abort and restart: abort at load index 100. Expect csb0=1 and busy=0 next cycle. A later start reloads from addr 0. A start pulse during SWEEP is ignored (delta sequence unchanged).
6. Reset mid-sweep: assert reset in SWEEP at delta=3. Expect delta=0, done=0, busy=0, csb0=1 after the next edge. Changing cfg_* mid-sweep does not alter the delta sequence.
